pe_datapath_unroll_inoutcha: RTL and testbench

Convolution PE datapath, successor to the out-channel-unrolled PE. Computes all OUT_CHANNEL outputs in parallel and IN_UNROLL input channels per cycle, so one window takes IN_CHANNEL/IN_UNROLL MAC cycles.

---
 rtl/pe_pkg.sv | 42 ++++
 rtl/pe_group_macc.sv | 90 +++++++++
 rtl/pe_datapath_unroll_inoutcha.sv | 257 +++++++++++++++++++++++++
 tb/tb_pe_datapath_unroll_inoutcha.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared constants, FSM encoding and arithmetic helpers for the convolution PE.
package pe_pkg;

    localparam string MODE_LINEAR  = "linear";
    localparam string MODE_RELU    = "relu";
    localparam string MODE_BN_RELU = "batchnorm_relu";

    // Wide signed working width for the narrowing arithmetic; comfortably
    // above any accumulator width the PE is configured for.
    localparam int SAT_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HOLD  = 2'd3
    } pe_state_t;

    // Product width plus headroom for summing 'terms' full-scale products.
    function automatic int acc_width(input int data_width, input int terms);
        return 2 * data_width + $clog2(terms);
    endfunction

    // Clamp a wide signed value into the signed range of a dw-bit word.
    function automatic logic signed [SAT_W-1:0] sat_narrow(
        input logic signed [SAT_W-1:0] v,
        input int                      dw
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/pe_group_macc.sv
// One output channel: multiplies one input-channel group of the latched window
// against this channel's kernel, sums the lanes and accumulates over groups.
module pe_group_macc
    import pe_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int IN_CHANNEL = 16,
    parameter int IN_UNROLL  = 4,
    parameter int KERNEL_PTS = 9,
    parameter int ACC_W      = 40,
    parameter int GRP_W      = 2
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic [DATA_WIDTH*IN_CHANNEL*KERNEL_PTS-1:0] window,
    input  logic [DATA_WIDTH*IN_CHANNEL*KERNEL_PTS-1:0] weights,
    input  logic [GRP_W-1:0]                        grp,
    input  logic                                    acc_en,
    input  logic                                    acc_clr,
    output logic signed [ACC_W-1:0]                 acc
);

    localparam int GROUPS = IN_CHANNEL / IN_UNROLL;
    localparam int TERMS  = IN_UNROLL * KERNEL_PTS;
    localparam int PROD_W = 2 * DATA_WIDTH;

    logic [DATA_WIDTH-1:0]    lane_x [TERMS];
    logic [DATA_WIDTH-1:0]    lane_w [TERMS];
    logic signed [PROD_W-1:0] prod_q [TERMS];
    logic signed [ACC_W-1:0]  tree_d;
    logic signed [ACC_W-1:0]  tree_q;

    // steer the active channel group onto the multiplier lanes
    always_comb begin
        for (int t = 0; t < TERMS; t++) begin
            lane_x[t] = '0;
            lane_w[t] = '0;
        end
        for (int gi = 0; gi < GROUPS; gi++) begin
            if (grp == GRP_W'(gi)) begin
                for (int p = 0; p < KERNEL_PTS; p++) begin
                    for (int u = 0; u < IN_UNROLL; u++) begin
                        lane_x[p*IN_UNROLL+u] = window[(p*IN_CHANNEL + gi*IN_UNROLL + u)*DATA_WIDTH +: DATA_WIDTH];
                        lane_w[p*IN_UNROLL+u] = weights[(p*IN_CHANNEL + gi*IN_UNROLL + u)*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
        end
    end

    // registered full-width signed products
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int t = 0; t < TERMS; t++) begin
                prod_q[t] <= '0;
            end
        end else begin
            for (int t = 0; t < TERMS; t++) begin
                prod_q[t] <= PROD_W'($signed(lane_x[t])) * PROD_W'($signed(lane_w[t]));
            end
        end
    end

    // adder tree across all lanes of the group
    always_comb begin
        tree_d = '0;
        for (int t = 0; t < TERMS; t++) begin
            tree_d = tree_d + ACC_W'(prod_q[t]);
        end
    end

    // adder tree output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tree_q <= '0;
        end else begin
            tree_q <= tree_d;
        end
    end

    // accumulator; the first group of a window overwrites instead of adding
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (acc_en) begin
            acc <= acc_clr ? tree_q : acc + tree_q;
        end
    end

endmodule

// File: rtl/pe_datapath_unroll_inoutcha.sv
// Convolution PE: all output channels in parallel, IN_UNROLL input channels
// per cycle, ready/valid on both sides, saturating output with optional relu
// or batchnorm+relu.
//
//   state | meaning
//   IDLE  | i_ready=1, waiting for a window
//   ACCUM | stepping channel groups 0..G-1 through the MACs
//   DRAIN | letting the fixed pipeline empty (3 cycles, 5 with batchnorm)
//   HOLD  | o_valid=1, o_data stable until o_ready
module pe_datapath_unroll_inoutcha
    import pe_pkg::*;
#(
    parameter int    DATA_WIDTH            = 16,
    parameter int    FRAC_BITS             = 8,
    parameter int    IN_CHANNEL            = 16,
    parameter int    OUT_CHANNEL           = 32,
    parameter int    IN_UNROLL             = 4,
    parameter int    KERNEL_0              = 3,
    parameter int    KERNEL_1              = 3,
    parameter string OUTPUT_MODE           = "linear",
    parameter int    KERNEL_BASE_ADDR      = 23,
    parameter int    BIAS_BASE_ADDR        = KERNEL_BASE_ADDR + KERNEL_0*KERNEL_1*IN_CHANNEL*OUT_CHANNEL,
    parameter int    BATCHNORM_A_BASE_ADDR = BIAS_BASE_ADDR + OUT_CHANNEL,
    parameter int    BATCHNORM_B_BASE_ADDR = BATCHNORM_A_BASE_ADDR + OUT_CHANNEL
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic [DATA_WIDTH*IN_CHANNEL*KERNEL_0*KERNEL_1-1:0] i_data,
    input  logic                                         i_valid,
    output logic                                         i_ready,
    output logic [DATA_WIDTH*OUT_CHANNEL-1:0]            o_data,
    output logic                                         o_valid,
    input  logic                                         o_ready,
    input  logic [DATA_WIDTH-1:0]                        weight_data,
    input  logic [31:0]                                  weight_addr,
    input  logic                                         weight_we,
    output logic                                         busy
);

    localparam int KERNEL_PTS = KERNEL_0 * KERNEL_1;
    localparam int GROUPS     = IN_CHANNEL / IN_UNROLL;
    localparam int GRP_W      = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int ACC_W      = acc_width(DATA_WIDTH, KERNEL_PTS * IN_CHANNEL);
    localparam int W_PER_OC   = KERNEL_PTS * IN_CHANNEL;
    localparam int N_W        = W_PER_OC * OUT_CHANNEL;
    localparam int KW_AW      = (N_W > 1) ? $clog2(N_W) : 1;
    localparam int WIN_W      = DATA_WIDTH * IN_CHANNEL * KERNEL_PTS;
    localparam bit IS_RELU    = (OUTPUT_MODE == MODE_RELU);
    localparam bit IS_BN      = (OUTPUT_MODE == MODE_BN_RELU);
    localparam int DRAIN_CYC  = IS_BN ? 5 : 3;
    localparam int CNT_W      = 3;

    localparam logic [31:0] KERN_BASE = 32'(KERNEL_BASE_ADDR);
    localparam logic [31:0] BIAS_BASE = 32'(BIAS_BASE_ADDR);
    localparam logic [31:0] BN_A_BASE = 32'(BATCHNORM_A_BASE_ADDR);
    localparam logic [31:0] BN_B_BASE = 32'(BATCHNORM_B_BASE_ADDR);

    if (IN_CHANNEL % IN_UNROLL != 0) begin : g_bad_unroll
        $error("IN_UNROLL must divide IN_CHANNEL");
    end

    pe_state_t               state;
    pe_state_t               state_nxt;
    logic [GRP_W-1:0]        g;
    logic [CNT_W-1:0]        drain_cnt;
    logic                    last_grp;
    logic [WIN_W-1:0]        win_q;
    logic                    s1_vld, s1_first, s1_last;
    logic                    s2_vld, s2_first, s2_last;
    logic                    done3;
    logic                    kern_hit;
    logic [KW_AW-1:0]        kern_off;
    logic [DATA_WIDTH-1:0]   kern_mem [N_W];

    assign last_grp = (g == GRP_W'(GROUPS - 1));

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next state and handshake outputs
    always_comb begin
        state_nxt = state;
        i_ready   = 1'b0;
        o_valid   = 1'b0;
        busy      = 1'b1;
        case (state)
            ST_IDLE: begin
                i_ready = 1'b1;
                busy    = 1'b0;
                if (i_valid) state_nxt = ST_ACCUM;
            end
            ST_ACCUM: begin
                if (last_grp) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (drain_cnt == '0) state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                o_valid = 1'b1;
                if (o_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // group counter and drain down-counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g         <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                ST_ACCUM: begin
                    g <= last_grp ? '0 : g + GRP_W'(1);
                    if (last_grp) drain_cnt <= CNT_W'(DRAIN_CYC - 1);
                end
                ST_DRAIN: begin
                    if (drain_cnt != '0) drain_cnt <= drain_cnt - CNT_W'(1);
                end
                default: g <= '0;
            endcase
        end
    end

    // capture the window on the accepting edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q <= '0;
        end else if (state == ST_IDLE && i_valid) begin
            win_q <= i_data;
        end
    end

    // control flags travelling alongside the product and tree registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {s1_vld, s1_first, s1_last} <= '0;
            {s2_vld, s2_first, s2_last} <= '0;
            done3                       <= 1'b0;
        end else begin
            s1_vld   <= (state == ST_ACCUM);
            s1_first <= (g == '0);
            s1_last  <= last_grp;
            s2_vld   <= s1_vld;
            s2_first <= s1_first;
            s2_last  <= s1_last;
            done3    <= s2_vld && s2_last;
        end
    end

    assign kern_hit = weight_addr >= KERN_BASE && weight_addr < KERN_BASE + 32'(N_W);
    assign kern_off = KW_AW'(weight_addr - KERN_BASE);

    // kernel weight RAM; not reset so weights survive rst_n
    always_ff @(posedge clk) begin
        if (weight_we && kern_hit) kern_mem[kern_off] <= weight_data;
    end

    for (genvar oc = 0; oc < OUT_CHANNEL; oc++) begin : g_oc
        logic [WIN_W-1:0]               wts;
        logic signed [ACC_W-1:0]        acc;
        logic [DATA_WIDTH-1:0]          bias_q;
        logic signed [SAT_W-1:0]        biased;
        logic signed [SAT_W-1:0]        narrowed;
        logic signed [DATA_WIDTH-1:0]   y0_q;

        for (genvar j = 0; j < W_PER_OC; j++) begin : g_w
            assign wts[j*DATA_WIDTH +: DATA_WIDTH] = kern_mem[oc*W_PER_OC + j];
        end

        pe_group_macc #(
            .DATA_WIDTH (DATA_WIDTH),
            .IN_CHANNEL (IN_CHANNEL),
            .IN_UNROLL  (IN_UNROLL),
            .KERNEL_PTS (KERNEL_PTS),
            .ACC_W      (ACC_W),
            .GRP_W      (GRP_W)
        ) u_macc (
            .clk     (clk),
            .rst_n   (rst_n),
            .window  (win_q),
            .weights (wts),
            .grp     (g),
            .acc_en  (s2_vld),
            .acc_clr (s2_first),
            .acc     (acc)
        );

        // bias word for this channel; not reset
        always_ff @(posedge clk) begin
            if (weight_we && weight_addr == BIAS_BASE + 32'(oc)) bias_q <= weight_data;
        end

        // add bias, drop fraction toward -inf, clamp, optional relu
        always_comb begin
            biased   = SAT_W'(acc) + (SAT_W'($signed(bias_q)) <<< FRAC_BITS);
            narrowed = sat_narrow(biased >>> FRAC_BITS, DATA_WIDTH);
            if (IS_RELU && narrowed[SAT_W-1]) narrowed = '0;
        end

        // saturated result register, loaded once per window
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                y0_q <= '0;
            end else if (done3) begin
                y0_q <= narrowed[DATA_WIDTH-1:0];
            end
        end

        if (IS_BN) begin : g_bn
            logic [DATA_WIDTH-1:0]        a_q;
            logic [DATA_WIDTH-1:0]        b_q;
            logic                         done4, done5;
            logic signed [SAT_W-1:0]      scaled_q;
            logic signed [SAT_W-1:0]      bn_sum;
            logic signed [DATA_WIDTH-1:0] y_q;

            // batchnorm scale/offset words; not reset
            always_ff @(posedge clk) begin
                if (weight_we && weight_addr == BN_A_BASE + 32'(oc)) a_q <= weight_data;
                if (weight_we && weight_addr == BN_B_BASE + 32'(oc)) b_q <= weight_data;
            end

            // scale stage then offset/clamp/relu stage
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    done4    <= 1'b0;
                    done5    <= 1'b0;
                    scaled_q <= '0;
                    y_q      <= '0;
                end else begin
                    done4 <= done3;
                    done5 <= done4;
                    if (done4) scaled_q <= (SAT_W'(y0_q) * SAT_W'($signed(a_q))) >>> FRAC_BITS;
                    if (done5) y_q <= bn_sum[DATA_WIDTH-1:0];
                end
            end

            // offset, clamp and relu of the scaled value
            always_comb begin
                bn_sum = sat_narrow(scaled_q + SAT_W'($signed(b_q)), DATA_WIDTH);
                if (bn_sum[SAT_W-1]) bn_sum = '0;
            end

            assign o_data[oc*DATA_WIDTH +: DATA_WIDTH] = y_q;
        end else begin : g_direct
            assign o_data[oc*DATA_WIDTH +: DATA_WIDTH] = y0_q;
        end
    end

endmodule

// File: tb/tb_pe_datapath_unroll_inoutcha.sv
// Bench for the PE: three instances (linear, relu, batchnorm_relu) on a shared
// weight bus, checked against an integer reference model of the conv math.
module tb_pe_datapath_unroll_inoutcha;

    localparam int DW  = 16;
    localparam int FB  = 8;
    localparam int IC  = 4;
    localparam int OC  = 2;
    localparam int U   = 2;
    localparam int KP  = 9;
    localparam int KB  = 23;
    localparam int BB  = KB + KP * IC * OC;
    localparam int AB  = BB + OC;
    localparam int BNB = AB + OC;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [DW*IC*KP-1:0] i_data;
    logic                iv   [3];
    logic                ordy [3];
    logic                irdy [3];
    logic                ov   [3];
    logic                bsy  [3];
    logic [DW*OC-1:0]    od   [3];
    logic [DW-1:0]       weight_data;
    logic [31:0]         weight_addr;
    logic                weight_we;

    int wm [OC][KP][IC];
    int xm [KP][IC];
    int bm [OC];
    int am [OC];
    int bnm[OC];

    int n_cmp = 0;
    int n_mis = 0;

    pe_datapath_unroll_inoutcha #(.DATA_WIDTH(DW), .FRAC_BITS(FB), .IN_CHANNEL(IC), .OUT_CHANNEL(OC),
        .IN_UNROLL(U), .KERNEL_0(3), .KERNEL_1(3), .OUTPUT_MODE("linear")) u_lin (
        .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_valid(iv[0]), .i_ready(irdy[0]),
        .o_data(od[0]), .o_valid(ov[0]), .o_ready(ordy[0]), .weight_data(weight_data),
        .weight_addr(weight_addr), .weight_we(weight_we), .busy(bsy[0]));

    pe_datapath_unroll_inoutcha #(.DATA_WIDTH(DW), .FRAC_BITS(FB), .IN_CHANNEL(IC), .OUT_CHANNEL(OC),
        .IN_UNROLL(U), .KERNEL_0(3), .KERNEL_1(3), .OUTPUT_MODE("relu")) u_relu (
        .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_valid(iv[1]), .i_ready(irdy[1]),
        .o_data(od[1]), .o_valid(ov[1]), .o_ready(ordy[1]), .weight_data(weight_data),
        .weight_addr(weight_addr), .weight_we(weight_we), .busy(bsy[1]));

    pe_datapath_unroll_inoutcha #(.DATA_WIDTH(DW), .FRAC_BITS(FB), .IN_CHANNEL(IC), .OUT_CHANNEL(OC),
        .IN_UNROLL(U), .KERNEL_0(3), .KERNEL_1(3), .OUTPUT_MODE("batchnorm_relu")) u_bn (
        .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_valid(iv[2]), .i_ready(irdy[2]),
        .o_data(od[2]), .o_valid(ov[2]), .o_ready(ordy[2]), .weight_data(weight_data),
        .weight_addr(weight_addr), .weight_we(weight_we), .busy(bsy[2]));

    function automatic longint sat16(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // mode: 0 linear, 1 relu, 2 batchnorm_relu
    function automatic logic [15:0] model(input int mode, input int oc);
        longint s;
        longint y;
        s = 0;
        for (int p = 0; p < KP; p++)
            for (int c = 0; c < IC; c++)
                s += longint'(wm[oc][p][c]) * longint'(xm[p][c]);
        y = sat16((s + longint'(bm[oc]) * 256) >>> FB);
        if (mode == 1 && y < 0) y = 0;
        if (mode == 2) begin
            y = sat16(((y * longint'(am[oc])) >>> FB) + longint'(bnm[oc]));
            if (y < 0) y = 0;
        end
        return 16'(y);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int addr, input int val);
        @(negedge clk);
        weight_we   = 1'b1;
        weight_addr = 32'(addr);
        weight_data = 16'(val);
        @(negedge clk);
        weight_we   = 1'b0;
    endtask

    task automatic load_all();
        for (int oc = 0; oc < OC; oc++)
            for (int p = 0; p < KP; p++)
                for (int c = 0; c < IC; c++)
                    wr(KB + (oc * KP + p) * IC + c, wm[oc][p][c]);
        for (int oc = 0; oc < OC; oc++) begin
            wr(BB + oc, bm[oc]);
            wr(AB + oc, am[oc]);
            wr(BNB + oc, bnm[oc]);
        end
        wr(KB - 1, 16'h5A5A);
        wr(BNB + OC, 16'hA5A5);
    endtask

    task automatic pack_x();
        for (int p = 0; p < KP; p++)
            for (int c = 0; c < IC; c++)
                i_data[(p * IC + c) * DW +: DW] = 16'(xm[p][c]);
    endtask

    task automatic fill(input int w0, input int w1, input int x, input int b);
        for (int p = 0; p < KP; p++)
            for (int c = 0; c < IC; c++) begin
                wm[0][p][c] = w0;
                wm[1][p][c] = w1;
                xm[p][c]    = x;
            end
        for (int oc = 0; oc < OC; oc++) bm[oc] = b;
    endtask

    task automatic start(input int k, input string tag);
        pack_x();
        @(negedge clk);
        chk({tag, "_irdy_pre"}, 32'(irdy[k]), 32'd1);
        iv[k] = 1'b1;
        @(posedge clk);
        #1;
        iv[k] = 1'b0;
    endtask

    task automatic wait_valid(input int k, input string tag);
        int n;
        n = 0;
        while (n < 40 && !ov[k]) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_lat"}, 32'(n), (k == 2) ? 32'd7 : 32'd5);
    endtask

    task automatic check_out(input int k, input string tag);
        for (int oc = 0; oc < OC; oc++)
            chk($sformatf("%s_oc%0d", tag, oc), {16'd0, od[k][oc*DW +: DW]}, {16'd0, model(k, oc)});
    endtask

    task automatic release_out(input int k, input string tag);
        @(negedge clk);
        ordy[k] = 1'b1;
        @(posedge clk);
        #1;
        ordy[k] = 1'b0;
        chk({tag, "_irdy_post"}, 32'(irdy[k]), 32'd1);
        chk({tag, "_ov_post"}, 32'(ov[k]), 32'd0);
    endtask

    task automatic run_window(input int k, input string tag);
        start(k, tag);
        wait_valid(k, tag);
        check_out(k, tag);
        release_out(k, tag);
    endtask

    task automatic run_all(input string tag);
        run_window(0, {tag, "_lin"});
        run_window(1, {tag, "_relu"});
        run_window(2, {tag, "_bn"});
    endtask

    initial begin
        logic [DW*OC-1:0] snap;
        for (int k = 0; k < 3; k++) begin
            iv[k]   = 1'b0;
            ordy[k] = 1'b0;
        end
        i_data      = '0;
        weight_data = '0;
        weight_addr = '0;
        weight_we   = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_irdy%0d", k), 32'(irdy[k]), 32'd1);
            chk($sformatf("rst_ov%0d", k), 32'(ov[k]), 32'd0);
            chk($sformatf("rst_busy%0d", k), 32'(bsy[k]), 32'd0);
            chk($sformatf("rst_odata%0d", k), od[k], 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // scenario 1: uniform weights, bias, batchnorm scale/offset
        fill(16'h0100, 16'h0100, 16'h0080, 16'h0040);
        for (int oc = 0; oc < OC; oc++) begin
            am[oc]  = 16'h0200;
            bnm[oc] = -256;
        end
        load_all();
        run_all("s1");
        chk("s1_lin_const", {16'd0, od[0][15:0]}, 32'h1240);
        chk("s1_bn_const", {16'd0, od[2][31:16]}, 32'h2380);

        // reset during the second ACCUM cycle; weights must survive
        start(0, "s6");
        @(posedge clk);
        #1;
        chk("s6_busy_accum", 32'(bsy[0]), 32'd1);
        chk("s6_irdy_accum", 32'(irdy[0]), 32'd0);
        rst_n = 1'b0;
        #2;
        chk("s6_ov_rst", 32'(ov[0]), 32'd0);
        chk("s6_irdy_rst", 32'(irdy[0]), 32'd1);
        chk("s6_odata_rst", od[0], 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("s6_irdy_rel", 32'(irdy[0]), 32'd1);
        chk("s6_busy_rel", 32'(bsy[0]), 32'd0);
        run_window(0, "s6_after");
        chk("s6_const", {16'd0, od[0][31:16]}, 32'h1240);

        // backpressure: o_ready low for 10 cycles with i_valid pulses
        start(0, "s4");
        wait_valid(0, "s4");
        snap = od[0];
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            iv[0]  = (i % 2 == 0);
            i_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                      $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                      $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            @(posedge clk);
            #1;
            chk($sformatf("s4_stable%0d", i), od[0], snap);
            chk($sformatf("s4_irdy%0d", i), 32'(irdy[0]), 32'd0);
            chk($sformatf("s4_ov%0d", i), 32'(ov[0]), 32'd1);
        end
        @(negedge clk);
        iv[0] = 1'b0;
        check_out(0, "s4_held");
        release_out(0, "s4");
        run_window(0, "s4_next");

        // saturation, positive then negative
        fill(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h0040);
        load_all();
        run_all("s2p");
        chk("s2p_const", {16'd0, od[0][15:0]}, 32'h7FFF);
        fill(16'h7FFF, 16'h7FFF, -32768, 16'h0040);
        pack_x();
        run_all("s2n");
        chk("s2n_const", {16'd0, od[0][15:0]}, 32'h8000);
        chk("s2n_relu", {16'd0, od[1][15:0]}, 32'h0000);

        // relu: negative channel 0, positive channel 1
        fill(-256, 16'h0100, 16'h0100, 0);
        load_all();
        run_all("s3");
        chk("s3_relu_oc0", {16'd0, od[1][15:0]}, 32'h0000);
        chk("s3_relu_oc1", {16'd0, od[1][31:16]}, 32'h2400);
        chk("s3_lin_oc0", {16'd0, od[0][15:0]}, 32'hDC00);

        // randomized windows; the last round uses full-range words
        for (int r = 0; r < 5; r++) begin
            for (int oc = 0; oc < OC; oc++) begin
                for (int p = 0; p < KP; p++)
                    for (int c = 0; c < IC; c++)
                        wm[oc][p][c] = (r == 4) ? int'($urandom_range(0, 65535)) - 32768
                                                : int'($urandom_range(0, 127)) - 64;
                bm[oc]  = int'($urandom_range(0, 4095)) - 2048;
                am[oc]  = int'($urandom_range(0, 2047)) - 1024;
                bnm[oc] = int'($urandom_range(0, 8191)) - 4096;
            end
            for (int p = 0; p < KP; p++)
                for (int c = 0; c < IC; c++)
                    xm[p][c] = (r == 4) ? int'($urandom_range(0, 65535)) - 32768
                                        : int'($urandom_range(0, 2047)) - 1024;
            load_all();
            run_all($sformatf("rnd%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
